// File: rtl/quantum_scheduler.sv
// quantum_scheduler: preemption timer and round-robin context controller.
// Times the running process's slice and saves its PC in a per-process table.
// Requests a jump to the scheduler routine, then picks the next ready slot.
// Supplies the restore PC when scheduler software commits the switch.
// Optional build macro: SCHED_IO_BLOCK_EN adds the io_block / io_wake ports.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | preemption disabled, quantum counter held
// RUN      | process running, quantum counting
// PREEMPT  | troca_contexto=11, waiting for the CPU to take the jump
// SELECT   | round-robin scan, one candidate slot per cycle
// WAIT_SW  | scan done, waiting for the software change-process instruction
// DISPATCH | troca_contexto=01 for one cycle, pc_restore is valid
module quantum_scheduler #(
   parameter int NUM_PROC = 8,
   parameter int PID_W    = 3,
   parameter int QUANTUM  = 100,
   parameter int PC_W     = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             pause,
   input  logic             cfg_we,
   input  logic [PID_W-1:0] cfg_pid,
   input  logic             cfg_ready,
   input  logic             switch_req,
   input  logic [PID_W-1:0] switch_pid,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             switch_ack,
`ifdef SCHED_IO_BLOCK_EN
   input  logic             io_block,
   input  logic             io_wake,
   input  logic [PID_W-1:0] io_wake_pid,
`endif
   output logic [1:0]       troca_contexto,
   output logic [PID_W-1:0] processo_atual,
   output logic [PID_W-1:0] processo_proximo,
   output logic [PC_W-1:0]  pc_restore,
   output logic [15:0]      quantum_count,
   output logic             no_ready
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      PREEMPT  = 3'd2,
      SELECT   = 3'd3,
      WAIT_SW  = 3'd4,
      DISPATCH = 3'd5
   } stateT;

   stateT             state;
   logic [NUM_PROC-1:0] readyTbl;
   logic [PC_W-1:0]   pcTbl [NUM_PROC];
   logic [PID_W-1:0]  scanPid;
   logic [PID_W-1:0]  scanCnt;

   logic              expiry;
   logic              ioBlockHit;
   logic [15:0]       countInc;
   logic [PC_W-1:0]   yieldRestore;

   // Slice ends on the last counting cycle; a paused cycle never expires.
   assign expiry   = (quantum_count == 16'(QUANTUM - 1)) && !pause;
   // Saturating increment so a long-running count never wraps to zero.
   assign countInc = (quantum_count == 16'hFFFF) ? quantum_count : quantum_count + 16'd1;
   // A yield back to the running pid must see the PC being saved this same cycle.
   assign yieldRestore = (switch_pid == processo_atual) ? pc_in : pcTbl[switch_pid];

`ifdef SCHED_IO_BLOCK_EN
   // Blocking only counts when the RUN branch would not take a yield or disable first.
   assign ioBlockHit = (state == RUN) && enable && !switch_req && io_block;
`else
   assign ioBlockHit = 1'b0;
`endif

   // Process ready table; cfg_we is applied last so it wins over I/O updates.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         readyTbl <= NUM_PROC'(1);
      end else begin
`ifdef SCHED_IO_BLOCK_EN
         if (ioBlockHit)
            readyTbl[processo_atual] <= 1'b0;
         if (io_wake)
            readyTbl[io_wake_pid] <= 1'b1;
`endif
         if (cfg_we)
            readyTbl[cfg_pid] <= cfg_ready;
      end
   end

   // Scheduler FSM with registered outputs and the saved-PC table.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         troca_contexto   <= 2'b00;
         processo_atual   <= '0;
         processo_proximo <= '0;
         pc_restore       <= '0;
         quantum_count    <= '0;
         no_ready         <= 1'b0;
         scanPid          <= '0;
         scanCnt          <= '0;
         for (int i = 0; i < NUM_PROC; i++)
            pcTbl[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  quantum_count <= '0;
                  state         <= RUN;
               end
            end

            RUN: begin
               if (switch_req) begin
                  // Voluntary yield takes priority over expiry; PC saved once.
                  pcTbl[processo_atual] <= pc_in;
                  processo_atual        <= switch_pid;
                  pc_restore            <= yieldRestore;
                  quantum_count         <= '0;
                  troca_contexto        <= 2'b01;
                  state                 <= DISPATCH;
               end else if (!enable) begin
                  state <= IDLE;
               end else begin
                  if (!pause)
                     quantum_count <= countInc;
                  if (expiry || ioBlockHit) begin
                     pcTbl[processo_atual] <= pc_in;
                     troca_contexto        <= 2'b11;
                     state                 <= PREEMPT;
                  end
               end
            end

            PREEMPT: begin
               if (switch_ack) begin
                  troca_contexto <= 2'b00;
                  scanPid        <= processo_atual + PID_W'(1);
                  scanCnt        <= '0;
                  state          <= SELECT;
               end
            end

            SELECT: begin
               if (readyTbl[scanPid]) begin
                  processo_proximo <= scanPid;
                  no_ready         <= 1'b0;
                  state            <= WAIT_SW;
               end else if (scanCnt == PID_W'(NUM_PROC - 2)) begin
                  // Every other slot checked; stay on the current process.
                  processo_proximo <= processo_atual;
                  no_ready         <= 1'b1;
                  state            <= WAIT_SW;
               end else begin
                  scanPid <= scanPid + PID_W'(1);
                  scanCnt <= scanCnt + PID_W'(1);
               end
            end

            WAIT_SW: begin
               if (switch_req) begin
                  processo_atual <= switch_pid;
                  pc_restore     <= pcTbl[switch_pid];
                  quantum_count  <= '0;
                  troca_contexto <= 2'b01;
                  state          <= DISPATCH;
               end
            end

            DISPATCH: begin
               troca_contexto <= 2'b00;
               quantum_count  <= '0;
               state          <= RUN;
            end

            default: begin
               troca_contexto <= 2'b00;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule
